// File: rtl/vlg_pulse_gen_pkg.sv
// Shared definitions for the pulse-train transmitter: FSM state encoding and period limits.
// Replaces the former vlg_pulse_defs.vh include; encodings are unchanged.
package vlg_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/vlg_pulse_gen_period_cnt.sv
// Loadable down-counter with zero flag; tracks position inside the current pulse period.
module vlg_pulse_period_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vlg_pulse_gen.sv
// Programmable pulse-train transmitter: period words in over valid/ready, rising edges of
// o_pulse spaced exactly PERIOD cycles apart, gapless when the shadow word is ready in time.
module vlg_pulse_gen
  import vlg_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned HIGH_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_vld,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_rdy,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_pulse_num
);

  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] HIGH_L = CNT_W'(HIGH_W);

  state_t           state, state_nxt;
  logic             shadow_vld;
  logic [CNT_W-1:0] shadow_period;
  logic [CNT_W-1:0] active_period;
  logic [CNT_W-1:0] p_m1;
  logic [CNT_W-1:0] h_len;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             accept;
  logic             short_word;
  logic             load;
  logic             dec;
  logic             pulse_q;
  logic             err_q;
  logic [CNT_W-1:0] pulse_num;

  assign o_rdy      = i_en & ~shadow_vld;
  assign accept     = i_vld & o_rdy;
  assign short_word = (i_period < MIN_P);

  // High time is clamped so every period keeps at least one low cycle.
  always_comb begin
    p_m1  = active_period - CNT_W'(1);
    h_len = (p_m1 < HIGH_L) ? p_m1 : HIGH_L;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dec       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (shadow_vld) begin
          load      = 1'b1;
          state_nxt = ST_HIGH;
        end
      end
      ST_HIGH: begin
        dec = 1'b1;
        if (cnt == active_period - h_len) state_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (cnt_zero) begin
          if (shadow_vld) begin
            load      = 1'b1;
            state_nxt = ST_HIGH;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          dec = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!i_en) begin
      state_nxt = ST_IDLE;
      load      = 1'b0;
      dec       = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      pulse_q       <= 1'b0;
      active_period <= '0;
      shadow_vld    <= 1'b0;
      shadow_period <= '0;
      err_q         <= 1'b0;
      pulse_num     <= '0;
    end else begin
      state   <= state_nxt;
      pulse_q <= (state_nxt == ST_HIGH);
      err_q   <= accept & short_word;
      if (load) active_period <= shadow_period;
      // Accept and consume are exclusive: o_rdy is only high while the shadow is empty.
      if (!i_en) begin
        shadow_vld <= 1'b0;
      end else if (accept) begin
        shadow_vld    <= 1'b1;
        shadow_period <= short_word ? MIN_P : i_period;
      end else if (load) begin
        shadow_vld <= 1'b0;
      end
      if (!i_en)     pulse_num <= '0;
      else if (load) pulse_num <= pulse_num + CNT_W'(1);
    end
  end

  vlg_pulse_period_cnt #(
    .CNT_W(CNT_W)
  ) u_period_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clear    (~i_en),
    .load     (load),
    .en       (dec),
    .load_val (shadow_period - CNT_W'(1)),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  assign o_pulse     = pulse_q;
  assign o_busy      = (state != ST_IDLE);
  assign o_done      = (state == ST_LOW) & cnt_zero;
  assign o_err       = err_q;
  assign o_pulse_num = pulse_num;

endmodule
